// File: rtl/key_action_if.sv
// key_action_if: raw keycode in, one-frame action keycode, event flag and gravity tick out.
interface key_action_if;
    logic [7:0] keycode_in;
    logic [7:0] keycode_out;
    logic       key_event;
    logic       drop_tick;
    modport master (output keycode_in, input keycode_out, key_event, drop_tick);
    modport slave  (input keycode_in, output keycode_out, key_event, drop_tick);
endinterface

// File: rtl/key_action_gen.sv
// key_action_gen: turns a level-held keycode into one-frame action pulses with DAS/ARR auto-repeat, plus a gravity tick.
module key_action_gen #(
    parameter int DAS_FRAMES     = 16,
    parameter int ARR_FRAMES     = 4,
    parameter int GRAVITY_FRAMES = 30
) (
    input logic         frame_clk,
    input logic         Reset,
    key_action_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, DAS = 2'd1, REP = 2'd2, HELD = 2'd3;
    localparam logic [7:0] DAS_LAST = 8'(DAS_FRAMES - 1);
    localparam logic [7:0] ARR_LAST = 8'(ARR_FRAMES - 1);
    localparam logic [7:0] GRAV_LAST = 8'(GRAVITY_FRAMES - 1);
    logic [1:0] state;
    logic [7:0] cur_key, cnt, gcnt, k;
    logic       rep, shot;
    always_comb begin
        rep  = bus.keycode_in == 8'h04 || bus.keycode_in == 8'h07;
        shot = bus.keycode_in == 8'h1A || bus.keycode_in == 8'h16 ||
               bus.keycode_in == 8'h14 || bus.keycode_in == 8'h2C;
        k    = (rep || shot) ? bus.keycode_in : 8'h00;
    end
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state           <= IDLE;
            cur_key         <= 8'h00;
            cnt             <= 8'h00;
            gcnt            <= 8'h00;
            bus.keycode_out <= 8'h00;
            bus.key_event   <= 1'b0;
            bus.drop_tick   <= 1'b0;
        end else begin
            gcnt          <= (gcnt == GRAV_LAST) ? 8'h00 : gcnt + 8'h01;
            bus.drop_tick <= gcnt == GRAV_LAST;
            if (k == 8'h00) begin
                state           <= IDLE;
                bus.keycode_out <= 8'h00;
                bus.key_event   <= 1'b0;
            end else if (state == IDLE || k != cur_key) begin
                state           <= rep ? DAS : HELD;
                cur_key         <= k;
                cnt             <= 8'h00;
                bus.keycode_out <= k;
                bus.key_event   <= 1'b1;
            end else if (state == DAS || state == REP) begin
                // both timers share cnt; only the terminal count differs
                if (cnt == ((state == DAS) ? DAS_LAST : ARR_LAST)) begin
                    state           <= REP;
                    cnt             <= 8'h00;
                    bus.keycode_out <= cur_key;
                    bus.key_event   <= 1'b1;
                end else begin
                    cnt             <= cnt + 8'h01;
                    bus.keycode_out <= 8'h00;
                    bus.key_event   <= 1'b0;
                end
            end else begin
                bus.keycode_out <= 8'h00;
                bus.key_event   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_key_action_gen.sv
// tb_key_action_gen: directed frame-by-frame checks of key filtering, DAS/ARR, one-shots, gravity and reset.
module tb_key_action_gen;
    logic frame_clk = 1'b0;
    logic Reset = 1'b1;
    int checks = 0;
    int failures = 0;
    key_action_if bus ();
    key_action_gen #(.DAS_FRAMES(16), .ARR_FRAMES(4), .GRAVITY_FRAMES(30)) dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .bus(bus.slave)
    );
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input int e, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s edge %0d: got %h want %h", tag, e, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e, input logic [7:0] exp_key, input logic exp_dt);
        chk({tag, "/keycode_out"}, e, bus.keycode_out, exp_key);
        chk({tag, "/key_event"}, e, {7'd0, bus.key_event}, {7'd0, exp_key != 8'h00});
        chk({tag, "/drop_tick"}, e, {7'd0, bus.drop_tick}, {7'd0, exp_dt});
    endtask

    task automatic tick(input logic [7:0] key);
        bus.keycode_in = key;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] key);
        Reset = 1'b1;
        tick(key);
        chk_all("reset", 0, 8'h00, 1'b0);
        Reset = 1'b0;
    endtask

    // repeatable key held from edge p with DAS=16, ARR=4
    function automatic logic rep_hit(input int e, input int p);
        return e == p || (e >= p + 16 && (e - p - 16) % 4 == 0);
    endfunction

    initial begin
        bus.keycode_in = 8'h00;
        do_reset(8'h00);
        // tap
        for (int e = 1; e <= 4; e++) begin
            tick(e <= 3 ? 8'h04 : 8'h00);
            chk_all("tap", e, e == 1 ? 8'h04 : 8'h00, 1'b0);
        end
        // auto-repeat
        do_reset(8'h00);
        for (int e = 1; e <= 32; e++) begin
            tick(e <= 30 ? 8'h07 : 8'h00);
            chk_all("autorep", e, (e <= 30 && rep_hit(e, 1)) ? 8'h07 : 8'h00, e == 30);
        end
        // one-shot, plus gravity over a full period
        do_reset(8'h00);
        for (int e = 1; e <= 31; e++) begin
            tick(e <= 20 ? 8'h1A : (e == 25 ? 8'h2C : 8'h00));
            chk_all("oneshot", e, e == 1 ? 8'h1A : (e == 25 ? 8'h2C : 8'h00), e == 30);
        end
        // key switch restarts DAS
        do_reset(8'h00);
        for (int e = 1; e <= 31; e++) begin
            tick(e <= 9 ? 8'h04 : 8'h07);
            chk_all("switch", e, e == 1 ? 8'h04 : ((e == 10 || e == 26 || e == 30) ? 8'h07 : 8'h00), e == 30);
        end
        // filter, unknown-as-release, release/re-press, one-shot change w->q
        do_reset(8'h00);
        for (int e = 1; e <= 14; e++) begin
            logic [7:0] kin, kexp;
            kin  = (e <= 5 || e == 8) ? 8'h05 : (e == 10 ? 8'h00 : (e == 12 ? 8'h1A : (e >= 13 ? 8'h14 : 8'h04)));
            kexp = (e == 6 || e == 9 || e == 11) ? 8'h04 : (e == 12 ? 8'h1A : (e == 13 ? 8'h14 : 8'h00));
            tick(kin);
            chk_all("filter", e, kexp, 1'b0);
        end
        // gravity and reset mid-hold
        do_reset(8'h00);
        for (int e = 1; e <= 40; e++) begin
            tick(e >= 31 ? 8'h04 : 8'h00);
            chk_all("grav1", e, (e >= 31 && rep_hit(e, 31)) ? 8'h04 : 8'h00, e == 30);
        end
        do_reset(8'h04);
        for (int e = 1; e <= 60; e++) begin
            tick(e <= 30 ? 8'h04 : 8'h00);
            chk_all("grav2", e, (e <= 30 && rep_hit(e, 1)) ? 8'h04 : 8'h00, e == 30 || e == 60);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_action_gen.md
# key_action_gen

Frame-rate keyboard conditioner that sits directly upstream of the falling-block mover. It turns the raw, level-held USB keycode into one-frame action pulses. Move keys get delayed auto-shift and auto-repeat; rotate and stop keys fire once per press. A gravity tick is generated for the drop logic. The mover consumes `keycode_out` in place of the raw keycode, so an idle frame presents 8'h00.

## Interface
- `DAS_FRAMES`, 16: frames from the first emission to the first auto-repeat; legal range 1..255.
- `ARR_FRAMES`, 4: frames between auto-repeats; legal range 1..255.
- `GRAVITY_FRAMES`, 30: period of `drop_tick`; legal range 1..255.
- `frame_clk`  in  1  frame clock (one edge per video frame).
- `Reset`  in  1  reset, synchronous, active-high.
- `keycode_in`  in  8  raw held keycode from the USB host; 8'h00 means no key.
- `keycode_out`  out  8  action keycode, valid for exactly one frame per action; 8'h00 otherwise.
- `key_event`  out  1  high when `keycode_out` != 8'h00.
- `drop_tick`  out  1  one-frame pulse every `GRAVITY_FRAMES` frames.

## Operation
- Key filter, combinational:
  - Repeatable set: 8'h04 (a), 8'h07 (d).
  - One-shot set: 8'h1A (w), 8'h16 (s), 8'h14 (q), 8'h2C (space).
  - Any other code filters to 8'h00 (treated as released).
- Registered state: `state` ∈ {IDLE, DAS, REP, HELD}, `cur_key`[7:0], `cnt`[7:0], `gcnt`[7:0]. All outputs are registered.
- Let k = filtered `keycode_in`. Per non-reset edge, evaluated in this priority order:
  - k == 0: go to IDLE, `keycode_out` <= 0.
  - k != 0 and (state == IDLE or k != `cur_key`): this is a new press.
    - `cur_key` <= k, `keycode_out` <= k, `cnt` <= 0.
    - state <= DAS if k is repeatable, else HELD.
  - DAS: if `cnt` == `DAS_FRAMES`-1, emit `cur_key`, `cnt` <= 0, state <= REP; else `cnt` += 1 and emit 0.
  - REP: if `cnt` == `ARR_FRAMES`-1, emit `cur_key` and `cnt` <= 0; else `cnt` += 1 and emit 0.
  - HELD: emit 0 and stay until release or a key change.
- Gravity, independent of keys:
  - If `gcnt` == `GRAVITY_FRAMES`-1: `gcnt` <= 0, `drop_tick` <= 1.
  - Otherwise `gcnt` += 1, `drop_tick` <= 0.
- `key_event` is registered together with `keycode_out` and is never high while `keycode_out` == 0.
- Counters are 8-bit. Compares are equality only, so there is no wrap inside the legal parameter range.

## Timing
- Edge numbering: edge n is the n-th non-reset `frame_clk` edge after `Reset` deasserts (n ≥ 1).
- Reset values: `keycode_out`=8'h00, `key_event`=0, `drop_tick`=0, state=IDLE, `cur_key`=0, `cnt`=0, `gcnt`=0.
- Latency: a press sampled at edge n appears on `keycode_out` after edge n and clears after edge n+1. Every action is exactly one frame wide.
- Repeatable key held from edge p emits after edges p, p+DAS, p+DAS+ARR, p+DAS+2·ARR, and so on.
- Release and re-press on consecutive frames: the re-press is a new press and emits immediately. There is no debounce beyond frame sampling.
- Key change without release (a→d, a→w, w→q) is a new press on that same edge. The DAS timer restarts.
- Unknown code while a valid key is held: treated as a release, so returning to the valid key re-emits.
- `Reset` mid-hold: all state clears. A key still held at the first non-reset edge is a new press and emits at edge 1.
- `drop_tick` is high after edges G, 2G, 3G, … (G = `GRAVITY_FRAMES`). With G=1 it is constantly high after edge 1.
- A key emission and `drop_tick` on the same frame are both asserted. There is no arbitration.

## Test plan
- Tap: `keycode_in`=8'h04 for edges 1–3, then 0 → `keycode_out`=8'h04 after edge 1 only; 0 after edges 2–4.
- Auto-repeat: 8'h07 held edges 1–30, DAS=16, ARR=4 → 8'h07 after edges 1, 17, 21, 25, 29 only; `key_event` mirrors.
- One-shot: 8'h1A held edges 1–20 → single 8'h1A after edge 1. 8'h2C tapped at edge 25 → 8'h2C after edge 25.
- Key switch: 8'h04 edges 1–9, then 8'h07 from edge 10 → emits at 1, 10, 26, 30. No 8'h04 emission after edge 9.
- Filter: 8'h05 held edges 1–5, then 8'h04 at edge 6 → no output at 1–5; 8'h04 after edge 6.
- Gravity and reset: G=30 → `drop_tick` after edges 30 and 60. `Reset` high for one edge after edge 40 while 8'h04 held → `keycode_out`=0 and `drop_tick`=0 during reset; 8'h04 emits at new edge 1; next `drop_tick` at new edge 30.
